// File: rtl/unidad_control_pila_pkg.sv
// Shared types and constants for the multi-cycle control unit and its return-address stack.
package unidad_control_pila_pkg;

    localparam int unsigned CLASS_W = 4;
    localparam int unsigned ALU3_W  = 3;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC  = 2'b01,
        HALT  = 2'b10,
        ERR   = 2'b11
    } estado_t;

    localparam logic [CLASS_W-1:0] CL_J    = 4'b1100;
    localparam logic [CLASS_W-1:0] CL_JZ   = 4'b1101;
    localparam logic [CLASS_W-1:0] CL_CALL = 4'b1110;
    localparam logic [CLASS_W-1:0] CL_SYS  = 4'b1111;

    localparam logic [1:0] SUB_RET = 2'b00;

    // ALU selects used by the four immediate classes 0000..0011
    localparam logic [ALU3_W-1:0] ALU_IMM0 = 3'b000;
    localparam logic [ALU3_W-1:0] ALU_IMM1 = 3'b010;
    localparam logic [ALU3_W-1:0] ALU_IMM2 = 3'b011;
    localparam logic [ALU3_W-1:0] ALU_IMM3 = 3'b110;

endpackage

// File: rtl/unidad_control_pila_retorno.sv
// LIFO of return addresses; only the pointer is reset, entries are don't-care after reset.
module pila_retorno #(
    parameter int unsigned PC_W        = 10,
    parameter int unsigned STACK_DEPTH = 4,
    localparam int unsigned SP_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic            reloj,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] top,
    output logic [SP_W-1:0] sp,
    output logic            full,
    output logic            empty
);

    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_W-1:0] mem [STACK_DEPTH];

    assign full  = (sp == SP_W'(STACK_DEPTH));
    assign empty = (sp == '0);
    assign top   = empty ? '0 : mem[IDX_W'(sp - SP_W'(1))];

    always_ff @(posedge reloj) begin
        if (!reset) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

    always_ff @(posedge reloj) begin
        if (push && !full) begin
            mem[IDX_W'(sp)] <= din;
        end
    end

endmodule

// File: rtl/unidad_control_pila.sv
// Fetch/execute control unit with jumps, CALL/RET on an internal stack, and sticky HALT/ERR.
module unidad_control_pila
    import unidad_control_pila_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 6,
    parameter int unsigned ALUOP_W     = 3,
    parameter int unsigned PC_W        = 10,
    parameter int unsigned STACK_DEPTH = 4,
    localparam int unsigned SP_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic                reloj,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                instr_valid,
    input  logic                zero,
    input  logic [PC_W-1:0]     pc_plus1,
    output logic                pc_en,
    output logic                s_inc,
    output logic                s_ret,
    output logic                s_inm,
    output logic                we3,
    output logic                wez,
    output logic [ALUOP_W-1:0]  op,
    output logic [PC_W-1:0]     ret_addr,
    output logic [SP_W-1:0]     sp,
    output logic                halted,
    output logic                err
);

    estado_t               state;
    estado_t               state_next;
    logic [OPCODE_W-1:0]   ir;
    logic [CLASS_W-1:0]    cls;
    logic [1:0]            sub;
    logic [ALU3_W-1:0]     op_base;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;

    assign cls = ir[OPCODE_W-1 -: CLASS_W];
    assign sub = ir[1:0];
    assign op  = ALUOP_W'(op_base);

    // Bits between class and sub-field carry no meaning for this unit
    if (OPCODE_W > 6) begin : g_mid
        logic unused_mid;
        assign unused_mid = ^ir[OPCODE_W-5:2];
    end

    // State and instruction register
    always_ff @(posedge reloj) begin
        if (!reset) begin
            state <= FETCH;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (state == FETCH && instr_valid) begin
                ir <= opcode;
            end
        end
    end

    // Next-state logic; stack faults and HALT are terminal until reset
    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (instr_valid) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = FETCH;
                if (cls == CL_CALL && full) begin
                    state_next = ERR;
                end else if (cls == CL_SYS) begin
                    if (sub != SUB_RET) begin
                        state_next = HALT;
                    end else if (empty) begin
                        state_next = ERR;
                    end
                end
            end
            default: state_next = state;
        endcase
    end

    // Output decode; strobes are only live in EXEC
    always_comb begin
        pc_en   = 1'b0;
        s_inc   = 1'b0;
        s_ret   = 1'b0;
        s_inm   = 1'b0;
        we3     = 1'b0;
        wez     = 1'b0;
        op_base = '0;
        push    = 1'b0;
        pop     = 1'b0;
        halted  = 1'b0;
        err     = 1'b0;
        case (state)
            EXEC: begin
                if (cls <= 4'd3) begin
                    pc_en = 1'b1;
                    s_inc = 1'b1;
                    s_inm = 1'b1;
                    we3   = 1'b1;
                    wez   = 1'b1;
                    case (cls[1:0])
                        2'd0:    op_base = ALU_IMM0;
                        2'd1:    op_base = ALU_IMM1;
                        2'd2: begin
                            op_base = ALU_IMM2;
                            we3     = 1'b0;
                        end
                        default: op_base = ALU_IMM3;
                    endcase
                end else if (cls < CL_J) begin
                    pc_en   = 1'b1;
                    s_inc   = 1'b1;
                    we3     = 1'b1;
                    wez     = 1'b1;
                    op_base = ALU3_W'(cls - 4'd4);
                end else begin
                    case (cls)
                        CL_J:  pc_en = 1'b1;
                        CL_JZ: begin
                            pc_en = 1'b1;
                            s_inc = ~zero;
                        end
                        CL_CALL: begin
                            pc_en = ~full;
                            push  = ~full;
                        end
                        default: begin
                            if (sub == SUB_RET) begin
                                s_ret = 1'b1;
                                pc_en = ~empty;
                                pop   = ~empty;
                            end
                        end
                    endcase
                end
            end
            HALT:    halted = 1'b1;
            ERR:     err    = 1'b1;
            default: ;
        endcase
    end

    pila_retorno #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_pila (
        .reloj (reloj),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_plus1),
        .top   (ret_addr),
        .sp    (sp),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: doc/unidad_control_pila.md
Name: unidad_control_pila

Overview:
- Parametrised multi-cycle successor to the single-cycle control unit of the simple CPU.
- Adds four things the previous unit lacks:
  - a fetch/execute FSM with an instruction-valid handshake;
  - unconditional and zero-conditional jumps;
  - CALL/RET backed by an internal return-address stack;
  - sticky HALT and error states.
- Sits between instruction memory/PC and the datapath: register file, ALU, zero-flag register.

Parameters:
- OPCODE_W, 6, opcode width. Minimum 6. Class is opcode[OPCODE_W-1 -: 4]; sub-field is opcode[1:0]; middle bits are ignored.
- ALUOP_W, 3, ALU operation select width. Minimum 3.
- PC_W, 10, program counter / return address width.
- STACK_DEPTH, 4, return-address stack entries. Minimum 1.

Ports:
- reloj  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 sampled on a rising edge of reloj resets the block).
- opcode  in  OPCODE_W  instruction opcode from instruction memory.
- instr_valid  in  1  opcode valid this cycle.
- zero  in  1  registered ALU zero flag.
- pc_plus1  in  PC_W  current PC+1 from datapath.
- pc_en  out  1  PC load strobe.
- s_inc  out  1  1: PC<=PC+1; 0: PC<=jump target or ret_addr.
- s_ret  out  1  1: PC source is ret_addr (only meaningful when s_inc=0).
- s_inm  out  1  1: ALU operand B is the immediate.
- we3  out  1  register file write enable.
- wez  out  1  zero-flag write enable.
- op  out  ALUOP_W  ALU operation.
- ret_addr  out  PC_W  top of return stack.
- sp  out  $clog2(STACK_DEPTH+1)  stack occupancy.
- halted  out  1  sticky halt indicator.
- err  out  1  sticky stack-fault indicator.

Behaviour:
- Reset (reset==0 at a rising edge): state=FETCH, ir=0, sp=0, stack contents don't-care.
  - Control outputs held at 0 whenever not in EXEC: pc_en, s_inc, s_ret, s_inm, we3, wez, op.
  - halted=0, err=0.
  - Reset takes priority in every state, including mid-EXEC, HALT and ERR.
- State FETCH:
  - instr_valid=1: ir<=opcode, next state EXEC.
  - Otherwise stay in FETCH.
- State EXEC, single cycle. Outputs are decoded from ir; pc_en=1 unless a halt or fault is detected.
- EXEC decode by class:
  - 0000: s_inc=1, s_inm=1, op=000, we3=1, wez=1.
  - 0001: s_inc=1, s_inm=1, op=010, we3=1, wez=1.
  - 0010: s_inc=1, s_inm=1, op=011, we3=0, wez=1. Compare only, no register write.
  - 0011: s_inc=1, s_inm=1, op=110, we3=1, wez=1.
  - 0100..1011: s_inc=1, s_inm=0, op=class-4 (000..111), we3=1, wez=1.
  - 1100 J: s_inc=0, s_ret=0, we3=0, wez=0.
  - 1101 JZ: s_inc=~zero, s_ret=0, we3=0, wez=0. zero is sampled in this EXEC cycle.
  - 1110 CALL: s_inc=0, s_ret=0. Pushes pc_plus1 at the end of the cycle; sp+1.
  - 1111, sub 00 RET: s_inc=0, s_ret=1, PC<=ret_addr. Pops; sp-1.
  - 1111, sub 01/10/11 HALT: pc_en=0. Next state HALT.
- Leaving EXEC: next state FETCH, except HALT or ERR as defined.
- Stack: LIFO.
  - ret_addr = entry[sp-1] when sp>0, else 0.
  - Push writes entry[sp].
  - Latency: a value pushed in cycle N is visible on ret_addr in cycle N+1.
- Stack boundary conditions:
  - CALL with sp==STACK_DEPTH (overflow): no push, pc_en=0, next state ERR.
  - RET with sp==0 (underflow): no pop, pc_en=0, next state ERR.
- State HALT: halted=1, all strobes 0, opcode ignored, exit only by reset.
- State ERR: err=1, same treatment as HALT.
- Throughput: 2 cycles per instruction when instr_valid is held high. instr_valid during EXEC is ignored.
- Width: op is zero-extended to ALUOP_W when ALUOP_W>3.

Decomposition:
- Shared package contents:
  - state enum FETCH/EXEC/HALT/ERR;
  - 4-bit class constants: CL_J=4'b1100, CL_JZ=4'b1101, CL_CALL=4'b1110, CL_SYS=4'b1111;
  - ALU op constants.
- Sub-module pila_retorno (parametrised PC_W, STACK_DEPTH).
  - Inputs: push, pop, din.
  - Outputs: top, sp, full, empty.
  - Synchronous active-low reset of the pointer only.

Test Plan:
- Reset then opcode=000100 with instr_valid=1 → EXEC cycle shows s_inc=1, s_inm=1, op=010, we3=1, wez=1, pc_en=1; back in FETCH next cycle.
- Opcode 010100 → op=001, s_inm=0; instr_valid=0 for 3 cycles → stays in FETCH with all strobes 0.
- JZ (110100): with zero=1 → s_inc=0, pc_en=1; with zero=0 → s_inc=1.
- CALL, pc_plus1=0x05A → sp=1, ret_addr=0x05A next cycle; then RET → s_ret=1, s_inc=0, sp=0.
- Overflow and underflow, STACK_DEPTH=4:
  - 5 CALLs → 5th asserts err=1, pc_en=0, sp stays 4; further opcodes ignored.
  - Separate run: RET at sp=0 → err=1.
- HALT (111101) → halted=1 and persists.
  - reset=0 during HALT → FETCH, halted=0, sp=0.
  - reset=0 mid-EXEC → outputs 0 next cycle.
